// File: rtl/mem_if_pkg.sv
// Shared definitions for the Mini-SRC memory access controller:
// default widths, controller state encoding and read-latency limits.
package mem_if_pkg;

   localparam int ADDR_W_DEF   = 9;
   localparam int DATA_W_DEF   = 32;

   localparam int READ_LAT_MIN = 1;
   localparam int READ_LAT_MAX = 7;

   // Wide enough to hold READ_LATENCY-1 for the largest legal latency
   localparam int CNT_W        = $clog2(READ_LAT_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } memState_t;

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator-side memory interface: latches a single read/write request into
// MAR/MDR, drives the synchronous RAM port and pulses done on completion.
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int READ_LATENCY = 1
)(
   input  logic              clock,
   input  logic              clear,
   input  logic              req,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rd_data,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data_in,
   input  logic [DATA_W-1:0] ram_data_out
);

   localparam logic [CNT_W-1:0] LAT_RELOAD = CNT_W'(READ_LATENCY - 1);

   memState_t          r_state;
   memState_t          w_nextState;
   logic [ADDR_W-1:0]  r_mar;
   logic [DATA_W-1:0]  r_mdr;
   logic               r_isWrite;
   logic [CNT_W-1:0]   r_count;
   logic [DATA_W-1:0]  r_rdData;
   logic               w_countZero;

   assign w_countZero = (r_count == '0);

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (req) w_nextState = ISSUE;
         ISSUE:   w_nextState = r_isWrite ? DONE : WAIT;
         WAIT:    if (w_countZero) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Request latching, read-latency countdown and read-data capture
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_mar     <= '0;
         r_mdr     <= '0;
         r_isWrite <= 1'b0;
         r_count   <= '0;
         r_rdData  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req) begin
                  r_mar     <= req_addr;
                  r_mdr     <= req_data;
                  r_isWrite <= req_write;
               end
            end
            ISSUE: begin
               if (!r_isWrite) r_count <= LAT_RELOAD;
            end
            WAIT: begin
               if (w_countZero) begin
                  r_rdData <= ram_data_out;
               end else begin
                  r_count <= r_count - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM strobes come only from the state register so a clear kills them at once
   assign busy        = (r_state != IDLE);
   assign done        = (r_state == DONE);
   assign ram_read    = (r_state == ISSUE) && !r_isWrite;
   assign ram_write   = (r_state == ISSUE) &&  r_isWrite;
   assign ram_address = r_mar;
   assign ram_data_in = r_mdr;
   assign rd_data     = r_rdData;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: two instances (read latency 1 and 3), each with
// its own RAM model, checked by vectors, corner sequences and random traffic.
module tb_mem_access_ctrl;

   logic clock;
   logic clear;

   logic        req1, reqWrite1;
   logic [8:0]  reqAddr1;
   logic [31:0] reqData1;
   logic        busy1, done1, ramRead1, ramWrite1;
   logic [31:0] rdData1, ramDataIn1, ramDataOut1;
   logic [8:0]  ramAddress1;

   logic        req3, reqWrite3;
   logic [8:0]  reqAddr3;
   logic [31:0] reqData3;
   logic        busy3, done3, ramRead3, ramWrite3;
   logic [31:0] rdData3, ramDataIn3, ramDataOut3;
   logic [8:0]  ramAddress3;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] ram1 [512];
   logic [31:0] ram3 [512];
   logic [31:0] refMem [2][512];
   logic [31:0] lastRd [2];
   logic [31:0] q1, s0, s1, s2;

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(1)) dut1 (
      .clock(clock), .clear(clear), .req(req1), .req_write(reqWrite1),
      .req_addr(reqAddr1), .req_data(reqData1), .busy(busy1), .done(done1),
      .rd_data(rdData1), .ram_read(ramRead1), .ram_write(ramWrite1),
      .ram_address(ramAddress1), .ram_data_in(ramDataIn1),
      .ram_data_out(ramDataOut1));

   mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .READ_LATENCY(3)) dut3 (
      .clock(clock), .clear(clear), .req(req3), .req_write(reqWrite3),
      .req_addr(reqAddr3), .req_data(reqData3), .busy(busy3), .done(done3),
      .rd_data(rdData3), .ram_read(ramRead3), .ram_write(ramWrite3),
      .ram_address(ramAddress3), .ram_data_in(ramDataIn3),
      .ram_data_out(ramDataOut3));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-cycle registered RAM for the latency-1 instance
   always @(posedge clock) begin
      if (ramWrite1) ram1[ramAddress1] = ramDataIn1;
      if (ramRead1)  q1 <= ram1[ramAddress1];
   end
   assign ramDataOut1 = q1;

   // Three-stage delayed RAM for the latency-3 instance
   always @(posedge clock) begin
      if (ramWrite3) ram3[ramAddress3] = ramDataIn3;
      if (ramRead3)  s0 <= ram3[ramAddress3];
      s1 <= s0;
      s2 <= s1;
   end
   assign ramDataOut3 = s2;

   typedef struct {
      logic        isWrite;
      logic [8:0]  addr;
      logic [31:0] data;
      logic [8:0]  afterAddr;
      int          expLat;
      logic [31:0] expRd;
   } vector_t;

   vector_t vec [8];

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic getDone(input int s);
      return (s == 1) ? done1 : done3;
   endfunction
   function automatic logic getBusy(input int s);
      return (s == 1) ? busy1 : busy3;
   endfunction
   function automatic logic getRamRead(input int s);
      return (s == 1) ? ramRead1 : ramRead3;
   endfunction
   function automatic logic getRamWrite(input int s);
      return (s == 1) ? ramWrite1 : ramWrite3;
   endfunction
   function automatic logic [8:0] getAddr(input int s);
      return (s == 1) ? ramAddress1 : ramAddress3;
   endfunction
   function automatic logic [31:0] getRd(input int s);
      return (s == 1) ? rdData1 : rdData3;
   endfunction

   task automatic driveReq(input int s, input logic r, input logic w,
                           input logic [8:0] a, input logic [31:0] d);
      if (s == 1) begin
         req1 = r; reqWrite1 = w; reqAddr1 = a; reqData1 = d;
      end else begin
         req3 = r; reqWrite3 = w; reqAddr3 = a; reqData3 = d;
      end
   endtask

   // One transaction: request at a negedge, scramble inputs after acceptance,
   // then count cycles (ISSUE = 1) until done is seen, bounded at 20.
   task automatic applyStimulus(input int s, input logic w, input logic [8:0] a,
                                input logic [31:0] d, input logic [8:0] afterAddr,
                                output int lat, output int rdPulses, output int wrPulses,
                                output logic [8:0] pulseAddr, output logic [31:0] rdOut,
                                output logic busyBad, output logic doneAfter);
      lat = 1; rdPulses = 0; wrPulses = 0; pulseAddr = '0; busyBad = 1'b0;
      @(negedge clock);
      driveReq(s, 1'b1, w, a, d);
      @(posedge clock); #1;
      driveReq(s, 1'b0, ~w, afterAddr, ~d);
      while (1) begin
         if (getRamRead(s))  begin rdPulses++; pulseAddr = getAddr(s); end
         if (getRamWrite(s)) begin wrPulses++; pulseAddr = getAddr(s); end
         if (getDone(s) && !getBusy(s)) busyBad = 1'b1;
         if (getDone(s)) break;
         if (lat >= 20) break;
         @(posedge clock); #1;
         lat++;
      end
      rdOut = getRd(s);
      @(posedge clock); #1;
      doneAfter = getDone(s);
   endtask

   // Runs a transaction and compares it against the reference memory model
   task automatic runTxn(input int s, input logic w, input logic [8:0] a,
                         input logic [31:0] d, input logic [8:0] afterAddr);
      int lat, rdP, wrP;
      logic [8:0] pAddr;
      logic [31:0] rdOut, expRd;
      logic busyBad, doneAfter;
      int m;
      m = (s == 1) ? 0 : 1;
      expRd = w ? lastRd[m] : refMem[m][a];
      applyStimulus(s, w, a, d, afterAddr, lat, rdP, wrP, pAddr, rdOut, busyBad, doneAfter);
      checkOutput("latency", lat, w ? 2 : ((s == 1) ? 3 : 5));
      checkOutput("rd_data", rdOut, expRd);
      checkOutput("ram_read_pulses", rdP, w ? 0 : 1);
      checkOutput("ram_write_pulses", wrP, w ? 1 : 0);
      checkOutput("ram_address", {23'd0, pAddr}, {23'd0, a});
      checkOutput("busy_with_done", {31'd0, busyBad}, 32'd0);
      checkOutput("done_one_cycle", {31'd0, doneAfter}, 32'd0);
      if (w) begin
         refMem[m][a] = d;
         checkOutput("ram_contents", (s == 1) ? ram1[a] : ram3[a], d);
      end else begin
         lastRd[m] = expRd;
      end
   endtask

   initial begin
      int heldRd, heldDone, heldIdle, doneSeen;
      logic heldBad;
      logic [8:0] rAddr;
      logic rW;

      for (int i = 0; i < 512; i++) begin
         ram1[i] = 32'd0; ram3[i] = 32'd0;
         refMem[0][i] = 32'd0; refMem[1][i] = 32'd0;
      end
      ram1[0] = 32'h01000095; ram1[149] = 32'h000000FF;
      ram3[0] = 32'h01000095; ram3[149] = 32'h000000FF;
      refMem[0][0] = 32'h01000095; refMem[0][149] = 32'h000000FF;
      refMem[1][0] = 32'h01000095; refMem[1][149] = 32'h000000FF;
      lastRd[0] = 32'd0; lastRd[1] = 32'd0;
      q1 = 32'd0; s0 = 32'd0; s1 = 32'd0; s2 = 32'd0;

      vec[0] = '{1'b0, 9'd149, 32'h0,        9'd0,   3, 32'h000000FF};
      vec[1] = '{1'b1, 9'd5,   32'hDEADBEEF, 9'd77,  2, 32'h000000FF};
      vec[2] = '{1'b0, 9'd5,   32'h0,        9'd5,   3, 32'hDEADBEEF};
      vec[3] = '{1'b0, 9'd149, 32'h0,        9'd0,   3, 32'h000000FF};
      vec[4] = '{1'b1, 9'd0,   32'h11112222, 9'd511, 2, 32'h000000FF};
      vec[5] = '{1'b0, 9'd0,   32'h0,        9'd149, 3, 32'h11112222};
      vec[6] = '{1'b1, 9'd511, 32'hCAFEF00D, 9'd0,   2, 32'h11112222};
      vec[7] = '{1'b0, 9'd511, 32'h0,        9'd1,   3, 32'hCAFEF00D};

      clear = 1'b1;
      driveReq(1, 1'b0, 1'b0, 9'd0, 32'd0);
      driveReq(3, 1'b0, 1'b0, 9'd0, 32'd0);
      #1;
      checkOutput("reset_busy", {30'd0, busy1, busy3}, 32'd0);
      checkOutput("reset_done", {30'd0, done1, done3}, 32'd0);
      checkOutput("reset_strobes", {28'd0, ramRead1, ramWrite1, ramRead3, ramWrite3}, 32'd0);
      checkOutput("reset_rd_data", rdData1 | rdData3, 32'd0);
      checkOutput("reset_mar_mdr", ramDataIn1 | {23'd0, ramAddress1}, 32'd0);
      @(negedge clock); @(negedge clock);
      clear = 1'b0;

      $display("[TB] table vectors, latency 1");
      for (int i = 0; i < 8; i++) begin
         int lat, rdP, wrP;
         logic [8:0] pAddr;
         logic [31:0] rdOut;
         logic busyBad, doneAfter;
         applyStimulus(1, vec[i].isWrite, vec[i].addr, vec[i].data, vec[i].afterAddr,
                       lat, rdP, wrP, pAddr, rdOut, busyBad, doneAfter);
         checkOutput("vec_latency", lat, vec[i].expLat);
         checkOutput("vec_rd_data", rdOut, vec[i].expRd);
         checkOutput("vec_read_pulses", rdP, vec[i].isWrite ? 0 : 1);
         checkOutput("vec_write_pulses", wrP, vec[i].isWrite ? 1 : 0);
         checkOutput("vec_address", {23'd0, pAddr}, {23'd0, vec[i].addr});
         checkOutput("vec_done_one_cycle", {31'd0, doneAfter}, 32'd0);
         if (vec[i].isWrite) begin
            refMem[0][vec[i].addr] = vec[i].data;
            checkOutput("vec_ram_contents", ram1[vec[i].addr], vec[i].data);
         end else begin
            lastRd[0] = vec[i].expRd;
         end
      end

      $display("[TB] latency 3: write then read 511");
      runTxn(3, 1'b1, 9'd511, 32'hA5A5A5A5, 9'd3);
      runTxn(3, 1'b0, 9'd511, 32'h0, 9'd0);

      $display("[TB] req held high reading address 0");
      heldRd = 0; heldDone = 0; heldIdle = 0; heldBad = 1'b0;
      @(negedge clock);
      driveReq(1, 1'b1, 1'b0, 9'd0, 32'd0);
      for (int k = 0; k < 12; k++) begin
         @(posedge clock); #1;
         if (ramRead1) heldRd++;
         if (done1) heldDone++;
         if (!busy1) heldIdle++;
         if (done1 && !busy1) heldBad = 1'b1;
      end
      driveReq(1, 1'b0, 1'b0, 9'd0, 32'd0);
      checkOutput("held_read_pulses", heldRd, 3);
      checkOutput("held_done_pulses", heldDone, 3);
      checkOutput("held_idle_cycles", heldIdle, 3);
      checkOutput("held_busy_with_done", {31'd0, heldBad}, 32'd0);
      checkOutput("held_rd_data", rdData1, refMem[0][0]);
      lastRd[0] = refMem[0][0];
      @(posedge clock); #1;
      checkOutput("held_back_idle", {31'd0, busy1}, 32'd0);

      $display("[TB] clear during write ISSUE");
      @(negedge clock);
      driveReq(1, 1'b1, 1'b1, 9'd149, 32'h12345678);
      @(posedge clock); #1;
      driveReq(1, 1'b0, 1'b0, 9'd0, 32'd0);
      checkOutput("issue_ram_write", {31'd0, ramWrite1}, 32'd1);
      clear = 1'b1;
      #1;
      checkOutput("clear_ram_write", {31'd0, ramWrite1}, 32'd0);
      checkOutput("clear_busy_done", {30'd0, busy1, done1}, 32'd0);
      checkOutput("clear_rd_data", rdData1, 32'd0);
      checkOutput("clear_mar_mdr", ramDataIn1 | {23'd0, ramAddress1}, 32'd0);
      @(posedge clock); #1;
      @(negedge clock);
      clear = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clock); #1;
         if (done1 || done3) doneSeen++;
      end
      checkOutput("clear_no_done", doneSeen, 0);
      checkOutput("clear_mem_kept", ram1[149], 32'h000000FF);
      lastRd[0] = 32'd0;
      lastRd[1] = 32'd0;
      runTxn(1, 1'b1, 9'd7, 32'h0BADF00D, 9'd149);

      $display("[TB] clear during read WAIT, latency 3");
      @(negedge clock);
      driveReq(3, 1'b1, 1'b0, 9'd511, 32'd0);
      @(posedge clock); #1;
      driveReq(3, 1'b0, 1'b0, 9'd0, 32'd0);
      @(posedge clock); #1;
      checkOutput("wait_busy", {31'd0, busy3}, 32'd1);
      clear = 1'b1;
      #1;
      checkOutput("wait_clear_rd_data", rdData3, 32'd0);
      checkOutput("wait_clear_busy", {31'd0, busy3}, 32'd0);
      @(negedge clock);
      clear = 1'b0;
      doneSeen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clock); #1;
         if (done3) doneSeen++;
      end
      checkOutput("wait_clear_no_done", doneSeen, 0);
      checkOutput("wait_clear_rd_hold", rdData3, 32'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0:       rAddr = 9'd0;
            1:       rAddr = 9'd511;
            default: rAddr = 9'($urandom_range(0, 15));
         endcase
         rW = 1'($urandom_range(0, 1));
         runTxn((i % 2 == 0) ? 1 : 3, rW, rAddr, $urandom, 9'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side memory interface for the Mini-SRC datapath. It accepts single-word read or write requests from the control unit, holds them in internal MAR/MDR registers, and drives the synchronous 512x32 RAM port (read, write, address, data in/out).
- For reads, it waits the RAM's registered read latency, captures the returned word, and signals completion with a one-cycle done pulse.

Parameters:
- ADDR_W, 9, RAM word-address width.
- DATA_W, 32, data word width.
- READ_LATENCY, 1, clock edges from the RAM sampling the address to ram_data_out holding valid data; legal range 1..7.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- clear  in  1  asynchronous, active-high reset.
- req  in  1  request strobe; sampled only in IDLE.
- req_write  in  1  1 = write, 0 = read; sampled with req.
- req_addr  in  ADDR_W  target word address; sampled with req.
- req_data  in  DATA_W  write data; sampled with req.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rd_data  out  DATA_W  last read word; holds until the next read completes.
- ram_read  out  1  RAM read strobe.
- ram_write  out  1  RAM write enable.
- ram_address  out  ADDR_W  RAM address; driven from the MAR register.
- ram_data_in  out  DATA_W  RAM write data; driven from the MDR register.
- ram_data_out  in  DATA_W  RAM registered read data.

Behaviour:
- Reset (clear = 1, asynchronous):
  - state = IDLE; MAR, MDR, rd_data and the wait counter = 0.
  - busy, done, ram_read and ram_write = 0 immediately.
- RAM outputs:
  - ram_read and ram_write are decoded from the state register only.
  - ram_address and ram_data_in come straight from the MAR and MDR registers.
  - No combinational path exists from req_* to any ram_* output.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req = 1 at a rising edge: MAR <= req_addr, MDR <= req_data, store the op type, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE (exactly one cycle):
  - Write: ram_write = 1, then go to DONE.
  - Read: ram_read = 1, counter <= READ_LATENCY-1, then go to WAIT.
  - The RAM samples the address/command at the edge that ends ISSUE.
- WAIT (read only, READ_LATENCY cycles):
  - ram_address stays stable; ram_read = 0.
  - If counter = 0 at an edge: rd_data <= ram_data_out, go to DONE.
  - Otherwise the counter decrements.
- DONE (one cycle): done = 1, busy = 1; go to IDLE.
- Timing:
  - Read with READ_LATENCY = 1: request accepted at edge E0; done is high in the cycle after E2; rd_data is valid from E2 onward.
  - Write: done is high in the cycle after E1; memory is updated at E1.
  - Read latency (acceptance edge to done cycle) = READ_LATENCY + 2 cycles; write = 2 cycles.
- Back-to-back operation:
  - req is ignored while busy (including the DONE cycle); nothing is queued and the requester re-asserts.
  - Minimum request spacing: read = READ_LATENCY + 3 cycles; write = 3 cycles.
- Boundaries:
  - Addresses 0 and 511 need no special handling; there is no wrap or increment logic.
  - req_write, req_addr and req_data may change freely after acceptance; the latched copies are used.
  - A write to address A followed by a read of A returns the new data.
- Reset mid-operation:
  - clear during ISSUE deasserts ram_write before the next edge, so the write is not performed.
  - clear during WAIT discards the read; rd_data = 0.
  - done never pulses after a clear.

Decomposition:
- Package mem_if_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state enum {IDLE, ISSUE, WAIT, DONE} (2-bit encoding);
  - the READ_LATENCY legal-range constant.
- A single flat module; the wait counter is small enough to stay inline, so no sub-module is needed.
- The testbench pairs this block with the existing RAM model (memory[0] = 0x01000095, memory[149] = 0x000000FF preloaded).

Test Plan:
- Read 149 after reset -> ram_read high for one cycle with ram_address = 149; done pulses 3 cycles after acceptance; rd_data = 0x000000FF.
- Write 0xDEADBEEF to 5, then read 5 -> write done 2 cycles after acceptance; the read returns 0xDEADBEEF; ram_write high for exactly one cycle.
- req held high continuously while reading address 0 -> exactly one transaction per IDLE visit; rd_data = 0x01000095; busy is never low in the same cycle as done.
- req_addr changed from 149 to 0 one cycle after acceptance -> ram_address stays 149; rd_data = 0x000000FF.
- clear asserted during ISSUE of a write of 0x12345678 to 149 -> ram_write drops immediately; memory[149] stays 0x000000FF; no done; outputs = 0.
- READ_LATENCY = 3 with a 3-stage delayed RAM model, reading 511 after writing 0xA5A5A5A5 -> done 5 cycles after acceptance; rd_data = 0xA5A5A5A5.
